// File: rtl/train_pkg.sv
// Shared types and constants for the XOR training sequencer and the network top.
package train_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        CHECK,
        UPDATE,
        DONE,
        FAIL
    } state_t;

    localparam int NUM_PATTERNS = 4;
    localparam int DEF_SCALE    = 1000;
    localparam int DEF_TOL      = 50;

    typedef logic signed [31:0] data_t;

    // Expected network output for a pattern index: (a ^ b) scaled to fixed point.
    function automatic data_t xor_target(input logic [1:0] idx, input int scale);
        return (idx[0] ^ idx[1]) ? data_t'(scale) : '0;
    endfunction

endpackage

// File: rtl/tol_window_check.sv
// Combinational pass/fail: net_out within +/-TOL of target and inside [0, SCALE].
module tol_window_check
    import train_pkg::*;
#(
    parameter int TOL   = DEF_TOL,
    parameter int SCALE = DEF_SCALE
) (
    input  data_t net_out,
    input  data_t target,
    output logic  pass
);

    localparam data_t TOL_W   = data_t'(TOL);
    localparam data_t SCALE_W = data_t'(SCALE);
    localparam data_t ZERO    = '0;

    data_t lo;
    data_t hi;

    assign lo   = target - TOL_W;
    assign hi   = target + TOL_W;
    assign pass = (net_out >= lo) && (net_out <= hi) &&
                  (net_out >= ZERO) && (net_out <= SCALE_W);

endmodule

// File: rtl/train_sequencer.sv
// Training controller: walks the four XOR patterns, strobes weight updates,
// scores each epoch against a tolerance window and declares converge/timeout.
module train_sequencer
    import train_pkg::*;
#(
    parameter int SCALE       = DEF_SCALE,
    parameter int TOL         = DEF_TOL,
    parameter int SETTLE      = 2,
    parameter int PASS_EPOCHS = 3,
    parameter int MAX_EPOCHS  = 5000
) (
    input  logic        Clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  data_t       net_out,
    output logic        pat_a,
    output logic        pat_b,
    output data_t       target,
    output logic [1:0]  pat_idx,
    output logic        train_en,
    output logic [15:0] epoch_cnt,
    output logic [3:0]  pass_mask,
    output logic        busy,
    output logic        converged,
    output logic        timeout
);

    localparam int                 SET_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'(SETTLE - 1);
    localparam logic [15:0]        PASS_TGT    = 16'(PASS_EPOCHS);
    localparam logic [15:0]        EPOCH_MAX   = 16'(MAX_EPOCHS);
    localparam logic [1:0]         LAST_IDX    = 2'(NUM_PATTERNS - 1);

    state_t                  state_q,  state_d;
    logic [1:0]              idx_q,    idx_d;
    data_t                   target_q, target_d;
    logic [15:0]             epoch_q,  epoch_d;
    logic [15:0]             run_q,    run_d;
    logic [NUM_PATTERNS-1:0] mask_q,   mask_d;
    logic [NUM_PATTERNS-1:0] wmask_q,  wmask_d;
    logic                    conv_q,   conv_d;
    logic                    tmo_q,    tmo_d;
    logic [SET_W-1:0]        settle_q, settle_d;
    logic                    pass;

    tol_window_check #(
        .TOL   (TOL),
        .SCALE (SCALE)
    ) u_window (
        .net_out (net_out),
        .target  (target_q),
        .pass    (pass)
    );

    always_comb begin
        // NOTE: every variable gets its hold value first, so no branch can infer a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        target_d = target_q;
        epoch_d  = epoch_q;
        run_d    = run_q;
        mask_d   = mask_q;
        wmask_d  = wmask_q;
        conv_d   = conv_q;
        tmo_d    = tmo_q;
        settle_d = settle_q;

        if (stop && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE, FAIL: begin
                    if (start) begin
                        state_d  = APPLY;
                        idx_d    = '0;
                        target_d = xor_target(2'd0, SCALE);
                        epoch_d  = '0;
                        run_d    = '0;
                        mask_d   = '0;
                        wmask_d  = '0;
                        conv_d   = 1'b0;
                        tmo_d    = 1'b0;
                        settle_d = '0;
                    end
                end
                APPLY: begin
                    if (settle_q == SETTLE_LAST) state_d = CHECK;
                    else                         settle_d = settle_q + 1'b1;
                end
                CHECK: begin
                    wmask_d[idx_q] = pass;
                    state_d        = UPDATE;
                end
                UPDATE: begin
                    if (idx_q != LAST_IDX) begin
                        idx_d    = idx_q + 2'd1;
                        target_d = xor_target(idx_q + 2'd1, SCALE);
                        settle_d = '0;
                        state_d  = APPLY;
                    end else begin
                        epoch_d = (epoch_q == 16'hFFFF) ? epoch_q : epoch_q + 16'd1;
                        mask_d  = wmask_q;
                        run_d   = (&wmask_q) ? run_q + 16'd1 : 16'd0;
                        // Convergence is tested first so it wins on the final epoch.
                        if (run_d == PASS_TGT) begin
                            conv_d  = 1'b1;
                            state_d = DONE;
                        end else if (epoch_d == EPOCH_MAX) begin
                            tmo_d   = 1'b1;
                            state_d = FAIL;
                        end else begin
                            idx_d    = '0;
                            target_d = xor_target(2'd0, SCALE);
                            wmask_d  = '0;
                            settle_d = '0;
                            state_d  = APPLY;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        // NOTE: non-blocking so every register samples the pre-edge values of the others.
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            target_q <= '0;
            epoch_q  <= '0;
            run_q    <= '0;
            mask_q   <= '0;
            wmask_q  <= '0;
            conv_q   <= 1'b0;
            tmo_q    <= 1'b0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            target_q <= target_d;
            epoch_q  <= epoch_d;
            run_q    <= run_d;
            mask_q   <= mask_d;
            wmask_q  <= wmask_d;
            conv_q   <= conv_d;
            tmo_q    <= tmo_d;
            settle_q <= settle_d;
        end
    end

    assign pat_idx   = idx_q;
    assign pat_a     = idx_q[0];
    assign pat_b     = idx_q[1];
    assign target    = target_q;
    assign epoch_cnt = epoch_q;
    assign pass_mask = mask_q;
    assign converged = conv_q;
    assign timeout   = tmo_q;
    assign train_en  = (state_q == UPDATE);
    assign busy      = (state_q == APPLY) || (state_q == CHECK) || (state_q == UPDATE);

endmodule

// File: tb/tb_train_sequencer.sv
// Bench for train_sequencer: cycle-count reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_train_sequencer;
    import train_pkg::*;

    localparam int SETTLE    = 2;
    localparam int PASS_EP   = 3;
    localparam int MAX_EP    = 6;
    localparam int SCALE     = 1000;
    localparam int TOL       = 50;
    localparam int PER_PAT   = SETTLE + 2;
    localparam int PER_EPOCH = 4 * PER_PAT;

    logic        Clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    data_t       net_out;
    logic        pat_a, pat_b;
    data_t       target;
    logic [1:0]  pat_idx;
    logic        train_en;
    logic [15:0] epoch_cnt;
    logic [3:0]  pass_mask;
    logic        busy, converged, timeout;

    int net_tbl [4];
    int n_checks = 0;
    int n_err    = 0;
    int te_count = 0;
    bit chk_en   = 1'b0;

    always #5 Clock = ~Clock;

    // Stand-in for the network: output is a lookup on the presented pattern.
    assign net_out = data_t'(net_tbl[{pat_b, pat_a}]);

    train_sequencer #(
        .SCALE       (SCALE),
        .TOL         (TOL),
        .SETTLE      (SETTLE),
        .PASS_EPOCHS (PASS_EP),
        .MAX_EPOCHS  (MAX_EP)
    ) dut (
        .Clock     (Clock),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .net_out   (net_out),
        .pat_a     (pat_a),
        .pat_b     (pat_b),
        .target    (target),
        .pat_idx   (pat_idx),
        .train_en  (train_en),
        .epoch_cnt (epoch_cnt),
        .pass_mask (pass_mask),
        .busy      (busy),
        .converged (converged),
        .timeout   (timeout)
    );

    // Reference model: position in the run is a plain cycle count within the epoch.
    typedef struct {
        bit       active;
        bit       done;
        bit       conv;
        bit       tmo;
        int       t;
        int       idx;
        int       epoch;
        int       run;
        bit [3:0] mask;
        bit [3:0] work;
    } model_t;

    model_t mdl;

    function automatic int tgt_of(input int i);
        return (i == 1 || i == 2) ? SCALE : 0;
    endfunction

    function automatic bit in_window(input int v, input int tgt);
        return (v >= tgt - TOL) && (v <= tgt + TOL) && (v >= 0) && (v <= SCALE);
    endfunction

    function automatic model_t step(input model_t m, input logic rst, input logic st,
                                    input logic sp, input int net);
        model_t n = m;
        int pat = m.t / PER_PAT;
        int pos = m.t % PER_PAT;
        if (!rst) begin
            n = '{default: 0};
        end else if (sp && (m.active || m.done)) begin
            n.active = 1'b0;
            n.done   = 1'b0;
        end else if (!m.active) begin
            if (st) begin
                n        = '{default: 0};
                n.active = 1'b1;
            end
        end else begin
            if (pos == PER_PAT - 2) n.work[pat] = in_window(net, tgt_of(pat));
            if (pos == PER_PAT - 1) begin
                if (pat < 3) begin
                    n.idx = pat + 1;
                end else begin
                    n.epoch = m.epoch + 1;
                    n.mask  = n.work;
                    n.run   = (n.work == 4'hF) ? m.run + 1 : 0;
                    if (n.run == PASS_EP) begin
                        n.conv = 1'b1; n.active = 1'b0; n.done = 1'b1;
                    end else if (n.epoch == MAX_EP) begin
                        n.tmo = 1'b1;  n.active = 1'b0; n.done = 1'b1;
                    end else begin
                        n.idx  = 0;
                        n.work = '0;
                    end
                end
            end
            n.t = (m.t + 1) % PER_EPOCH;
        end
        return n;
    endfunction

    always @(posedge Clock) mdl <= step(mdl, reset, start, stop, int'(net_out));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (chk_en) begin
            check("busy",      busy,      mdl.active);
            check("train_en",  train_en,  mdl.active && (mdl.t % PER_PAT == PER_PAT - 1));
            check("pat_idx",   pat_idx,   mdl.idx[1:0]);
            check("pat_a",     pat_a,     mdl.idx[0]);
            check("pat_b",     pat_b,     mdl.idx[1]);
            check("target",    target,    tgt_of(mdl.idx));
            check("epoch_cnt", epoch_cnt, mdl.epoch);
            check("pass_mask", pass_mask, mdl.mask);
            check("converged", converged, mdl.conv);
            check("timeout",   timeout,   mdl.tmo);
        end
    end

    always @(negedge Clock) if (train_en === 1'b1) te_count <= te_count + 1;

    task automatic set_exact();
        for (int i = 0; i < 4; i++) net_tbl[i] = tgt_of(i);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
    endtask

    task automatic wait_epoch(input int n);
        int k = 0;
        while (epoch_cnt != 16'(n) && k < 300) begin
            @(negedge Clock);
            k++;
        end
        check("wait_epoch", epoch_cnt, n);
    endtask

    function automatic int rand_val(input int i);
        int r = int'($urandom_range(0, 9));
        if (r < 6) return tgt_of(i);
        if (r < 9) return tgt_of(i) + int'($urandom_range(0, 160)) - 80;
        return int'($urandom_range(0, 1400)) - 200;
    endfunction

    initial begin
        int n;
        int te_mark;
        set_exact();
        repeat (3) @(negedge Clock);
        chk_en = 1'b1;

        // Reset state
        check("rst_busy",   busy, 0);
        check("rst_epoch",  epoch_cnt, 0);
        check("rst_target", target, 0);
        check("rst_flags",  {converged, timeout, train_en, pass_mask}, 0);
        reset = 1'b1;
        @(negedge Clock);

        // Exact outputs: converge after 3 epochs, 48 cycles after start is sampled
        te_mark = te_count;
        pulse_start();
        n = 0;
        while (!converged && n < 400) begin
            @(negedge Clock);
            n++;
        end
        check("conv_cycles",   n, 48);
        check("conv_train_en", te_count - te_mark, 12);
        check("conv_mask",     pass_mask, 4'hF);
        check("conv_epoch",    epoch_cnt, 3);
        check("conv_busy",     busy, 0);

        // Window edges
        net_tbl[0] = -1; net_tbl[1] = 949; net_tbl[2] = 1001; net_tbl[3] = 0;
        pulse_start();
        wait_epoch(1);
        check("win_mask_e1", pass_mask, 4'b1000);
        net_tbl[0] = 50; net_tbl[1] = 950; net_tbl[2] = 975; net_tbl[3] = -50;
        wait_epoch(2);
        check("win_mask_e2", pass_mask, 4'b0111);
        stop = 1'b1;
        @(negedge Clock);
        stop = 1'b0;
        check("win_stop_idle", busy, 0);

        // Stop mid-APPLY of idx2 in the second epoch (start held too: stop wins)
        set_exact();
        pulse_start();
        wait_epoch(1);
        n = 0;
        while (pat_idx != 2'd2 && n < 50) begin
            @(negedge Clock);
            n++;
        end
        check("stop_reach_idx2", pat_idx, 2);
        stop = 1'b1; start = 1'b1;
        check("stop_cycle_te", train_en, 0);
        @(negedge Clock);
        stop = 1'b0; start = 1'b0;
        check("stop_busy",  busy, 0);
        check("stop_te",    train_en, 0);
        check("stop_epoch", epoch_cnt, 1);
        pulse_start();
        check("restart_epoch", epoch_cnt, 0);
        check("restart_busy",  busy, 1);

        // Run reset by a failing epoch; convergence lands on the epoch limit and wins
        wait_epoch(2);
        net_tbl[3] = 500;
        wait_epoch(3);
        check("run_fail_mask", pass_mask, 4'b0111);
        net_tbl[3] = 0;
        wait_epoch(5);
        check("run_e5_conv", converged, 0);
        check("run_e5_mask", pass_mask, 4'hF);
        wait_epoch(6);
        check("run_e6_conv", converged, 1);
        check("run_e6_tmo",  timeout, 0);

        // Stuck output: timeout at the epoch limit
        for (int i = 0; i < 4; i++) net_tbl[i] = 500;
        pulse_start();
        n = 0;
        while (!timeout && n < 300) begin
            @(negedge Clock);
            n++;
        end
        check("tmo_flag",  timeout, 1);
        check("tmo_epoch", epoch_cnt, MAX_EP);
        check("tmo_conv",  converged, 0);
        check("tmo_mask",  pass_mask, 4'b0000);
        check("tmo_busy",  busy, 0);

        // Reset while train_en is high, with start and stop also high
        set_exact();
        pulse_start();
        n = 0;
        while (!train_en && n < 50) begin
            @(negedge Clock);
            n++;
        end
        check("rst_upd_te", train_en, 1);
        reset = 1'b0; start = 1'b1; stop = 1'b1;
        @(negedge Clock);
        check("rst_upd_outs",
              {busy, train_en, converged, timeout, pat_a, pat_b, pat_idx, pass_mask, epoch_cnt}, 0);
        check("rst_upd_target", target, 0);
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        @(negedge Clock);
        check("rst_upd_idle", busy, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int k;
            @(negedge Clock);
            reset = ($urandom_range(0, 999) != 0);
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) begin
                k = int'($urandom_range(0, 3));
                net_tbl[k] = rand_val(k);
            end
            if ($urandom_range(0, 199) == 0) set_exact();
        end
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        @(negedge Clock);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
